// File: rtl/lcd_field_drive.sv
// HD44780 8-bit write-only driver: power-on init, then renders NCH channels of DIGITS hex digits.
// Optional build macro LCD_LEADING_ZERO_BLANK_EN blanks leading zero digits within each channel.
module lcd_field_drive #(
    parameter int unsigned NCH     = 3,
    parameter int unsigned DIGITS  = 5,
    parameter int unsigned T_PWRON = 2000000,
    parameter int unsigned T_EN    = 50,
    parameter int unsigned T_CMD   = 5000,
    parameter int unsigned T_CLR   = 200000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH*4*DIGITS-1:0] VAL,
    input  logic                    VAL_STB,
    output logic [3:0]              STATE,
    output logic [10:0]             CTRL,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned CHB  = 4 * DIGITS;
    localparam int unsigned VW   = NCH * CHB;
    localparam int unsigned TM1  = (T_PWRON > T_CMD) ? T_PWRON : T_CMD;
    localparam int unsigned TM2  = (TM1 > T_CLR) ? TM1 : T_CLR;
    localparam int unsigned TMAX = (TM2 > T_EN) ? TM2 : T_EN;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned NW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [3:0] {
        ST_PWRON = 4'd0,
        ST_FUNC  = 4'd1,
        ST_DISP  = 4'd2,
        ST_CLR   = 4'd3,
        ST_ENTRY = 4'd4,
        ST_IDLE  = 4'd8,
        ST_ADDR  = 4'd9,
        ST_DATA  = 4'd10,
        ST_NEXT  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   ch_q, ch_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [VW-1:0]   disp_q, disp_d;
    logic            pend_q, pend_d;
    logic            rs_q, rs_d;
    logic            e_q, e_d;
    logic [7:0]      db_q, db_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            xfer_done;
    logic [CW-1:0]   hold_last;
    logic [CHB-1:0]  chan_v;
    logic [3:0]      nib;
    logic [3:0]      nib_cur;
    logic [7:0]      ascii;
    logic [7:0]      addr_cmd;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    logic            seen_nz;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_PWRON;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
            ch_q     <= '0;
            dig_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            db_q     <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            db_q     <= db_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Main sequencing: power-on wait, transfer phases, refresh walk over channels/digits.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        dig_d     = dig_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        xfer_done = 1'b0;
        hold_last = (state_q == ST_CLR) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);

        case (state_q)
            ST_PWRON: begin
                if (cnt_q == CW'(T_PWRON - 1)) begin
                    state_d = ST_FUNC;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (pend_q) begin
                    disp_d  = shadow_q;
                    pend_d  = 1'b0;
                    ch_d    = '0;
                    dig_d   = '0;
                    state_d = ST_ADDR;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_NEXT: begin
                if (ch_q == NW'(NCH - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + NW'(1);
                    state_d = ST_ADDR;
                    phase_d = PH_SETUP;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_STROBE;
                        cnt_d   = '0;
                    end
                    PH_STROBE: begin
                        if (cnt_q == CW'(T_EN - 1)) begin
                            phase_d = PH_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    PH_HOLD: begin
                        if (cnt_q == hold_last) begin
                            xfer_done = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
        endcase

        if (xfer_done) begin
            phase_d = PH_SETUP;
            case (state_q)
                ST_FUNC:  state_d = ST_DISP;
                ST_DISP:  state_d = ST_CLR;
                ST_CLR:   state_d = ST_ENTRY;
                ST_ENTRY: state_d = ST_IDLE;
                ST_ADDR: begin
                    state_d = ST_DATA;
                    dig_d   = '0;
                end
                ST_DATA: begin
                    if (dig_q == DW'(DIGITS - 1)) begin
                        state_d = ST_NEXT;
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // Latest strobe wins; overrides the pending clear taken in IDLE the same cycle.
        if (VAL_STB) begin
            shadow_d = VAL;
            pend_d   = 1'b1;
        end
    end

    // Pin values for the next cycle, derived from the next state so RS/DB lead E by the setup cycle.
    always_comb begin
        chan_v  = '0;
        nib     = '0;
        nib_cur = '0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (ch_d == NW'(i)) chan_v = disp_d[i*CHB +: CHB];
        end
        for (int j = 0; j < DIGITS; j++) begin
            nib_cur = chan_v[(DIGITS-1-j)*4 +: 4];
            if (DW'(j) == dig_d) nib = nib_cur;
`ifdef LCD_LEADING_ZERO_BLANK_EN
            if ((DW'(j) <= dig_d) && (nib_cur != 4'd0)) seen_nz = 1'b1;
`endif
        end
        ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`ifdef LCD_LEADING_ZERO_BLANK_EN
        if (!seen_nz && (dig_d != DW'(DIGITS - 1))) ascii = 8'h20;
`endif
        addr_cmd = 8'h80 | 8'(32'(ch_d[0]) * 64 + 32'(ch_d >> 1) * (DIGITS + 1));

        rs_d = 1'b0;
        case (state_d)
            ST_FUNC:  db_d = 8'h38;
            ST_DISP:  db_d = 8'h0C;
            ST_CLR:   db_d = 8'h01;
            ST_ENTRY: db_d = 8'h06;
            ST_ADDR:  db_d = addr_cmd;
            ST_DATA: begin
                db_d = ascii;
                rs_d = 1'b1;
            end
            default:  db_d = 8'h00;
        endcase
        e_d    = (phase_d == PH_STROBE);
        busy_d = (state_d != ST_IDLE);
    end

    assign STATE = state_q;
    assign CTRL  = {rs_q, 1'b0, e_q, db_q};
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_lcd_field_drive.sv
// Randomised bench for lcd_field_drive: pin-level monitor against a byte-stream reference model.
module tb_lcd_field_drive;

    localparam int unsigned NCH     = 3;
    localparam int unsigned DIGITS  = 5;
    localparam int unsigned T_PWRON = 100;
    localparam int unsigned T_EN    = 4;
    localparam int unsigned T_CMD   = 10;
    localparam int unsigned T_CLR   = 40;
    localparam int unsigned W       = 4 * DIGITS;
    localparam int unsigned VW      = NCH * W;

    logic          CLK = 1'b0;
    logic          RST;
    logic [VW-1:0] VAL;
    logic          VAL_STB;
    logic [3:0]    STATE;
    logic [10:0]   CTRL;
    logic          BUSY;
    logic          DONE;

    int checks   = 0;
    int failures = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    int         done_cnt   = 0;
    bit         done_prev  = 1'b0;
    bit         done_long  = 1'b0;
    bit         rw_bad     = 1'b0;
    bit         e_prev     = 1'b0;
    bit         stable_bad = 1'b0;
    logic [8:0] cur_b, prev_b, pulse_b;
    int         high_cnt   = 0;
    int         low_cnt    = 0;
    int         hold_len   = 0;
    int         need_gap   = 0;

    lcd_field_drive #(
        .NCH(NCH), .DIGITS(DIGITS), .T_PWRON(T_PWRON),
        .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .CLK(CLK), .RST(RST), .VAL(VAL), .VAL_STB(VAL_STB),
        .STATE(STATE), .CTRL(CTRL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: records each E pulse's {RS,DB} and checks pulse width, gaps and pin stability.
    always @(negedge CLK) begin
        if (RST) begin
            e_prev     = 1'b0;
            low_cnt    = 0;
            hold_len   = 0;
            need_gap   = T_PWRON;
            stable_bad = 1'b0;
            done_prev  = 1'b0;
        end else begin
            cur_b = {CTRL[10], CTRL[7:0]};
            if (CTRL[9]) rw_bad = 1'b1;
            if (DONE) begin
                if (!done_prev) done_cnt++;
                else done_long = 1'b1;
            end
            done_prev = DONE;
            if (CTRL[8] && !e_prev) begin
                obs_q.push_back(cur_b);
                check_eq("setup_pins", 64'(prev_b), 64'(cur_b));
                check_eq("gap_len_ok", 64'(low_cnt >= need_gap), 64'(1));
                check_eq("hold_stable", 64'(stable_bad), 64'(0));
                stable_bad = 1'b0;
                pulse_b    = cur_b;
                high_cnt   = 1;
            end else if (CTRL[8]) begin
                high_cnt++;
                if (cur_b != pulse_b) stable_bad = 1'b1;
            end else if (e_prev) begin
                check_eq("e_width", 64'(high_cnt), 64'(T_EN));
                check_eq("strobe_stable", 64'(stable_bad), 64'(0));
                stable_bad = 1'b0;
                hold_len   = (pulse_b == 9'h001) ? T_CLR : T_CMD;
                need_gap   = hold_len + 1;
                low_cnt    = 1;
                if (cur_b != pulse_b) stable_bad = 1'b1;
            end else begin
                low_cnt++;
                if (low_cnt <= hold_len && cur_b != pulse_b) stable_bad = 1'b1;
            end
            e_prev = CTRL[8];
            prev_b = cur_b;
        end
    end

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    // Expected byte stream of one refresh: per channel a cursor command then its digits as ASCII.
    task automatic push_refresh(input logic [VW-1:0] v);
        logic [W-1:0] chv;
        logic [3:0]   nb;
        logic [7:0]   c8;
        int           addr;
        bit           seen;
        for (int c = 0; c < NCH; c++) begin
            addr = (c % 2) * 64 + (c / 2) * (DIGITS + 1);
            exp_q.push_back({1'b0, 8'(128 + addr)});
            chv  = v[c*W +: W];
            seen = 1'b0;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                nb = chv[4*d +: 4];
                c8 = (nb < 10) ? 8'(48 + int'(nb)) : 8'(55 + int'(nb));
                if (nb != 0) seen = 1'b1;
`ifdef LCD_LEADING_ZERO_BLANK_EN
                if (!seen && d != 0) c8 = 8'h20;
`endif
                exp_q.push_back({1'b1, c8});
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_eq({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic strobe(input logic [VW-1:0] v);
        @(negedge CLK);
        VAL     = v;
        VAL_STB = 1'b1;
        @(negedge CLK);
        VAL_STB = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_idle_in_time"}, 64'(n < budget), 64'(1));
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_done_in_time"}, 64'(n < budget), 64'(1));
        wait_idle(tag, 50);
    endtask

    task automatic wait_cond_state(input string tag, input logic [3:0] st, input int budget);
        int n = 0;
        while (STATE !== st && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_state_seen"}, 64'(n < budget), 64'(1));
    endtask

    task automatic wait_e_high(input string tag, input int budget);
        int n = 0;
        while (CTRL[8] !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_e_seen"}, 64'(n < budget), 64'(1));
    endtask

    task automatic do_refresh(input string tag, input logic [VW-1:0] v);
        int t = done_cnt + 1;
        push_refresh(v);
        strobe(v);
        wait_done(tag, t, 2000);
        compare_stream(tag);
        check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'(t));
    endtask

    function automatic logic [VW-1:0] rand_val();
        logic [VW-1:0] v;
        logic [W-1:0]  x;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            x = W'($urandom());
            x = x >> (4 * $urandom_range(DIGITS - 1, 0));
            v[c*W +: W] = x;
        end
        return v;
    endfunction

    initial begin
        logic [VW-1:0] v1, v2, v3;
        int            t;

        RST     = 1'b1;
        VAL     = '0;
        VAL_STB = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_state", 64'(STATE), 64'(0));
        check_eq("rst_ctrl",  64'(CTRL),  64'(0));
        check_eq("rst_busy",  64'(BUSY),  64'(1));
        check_eq("rst_done",  64'(DONE),  64'(0));

        push_init();
        RST = 1'b0;
        wait_idle("init", 1000);
        check_eq("init_state", 64'(STATE), 64'(8));
        check_eq("init_busy",  64'(BUSY),  64'(0));
        compare_stream("init");
        check_eq("init_no_done", 64'(done_cnt), 64'(0));

        do_refresh("basic", {20'h54321, 20'h00055, 20'h00097});
        do_refresh("hexmap", {W'($urandom()), 20'h00000, 20'hABCDE});
        do_refresh("zeros", {20'hF0F0F, 20'h00000, 20'h00097});
        for (int k = 0; k < 5; k++) do_refresh("rand", rand_val());

        // Mid-refresh strobes: the display stays on v1; v2 is superseded by v3.
        v1 = rand_val();
        v2 = rand_val();
        v3 = rand_val();
        v3[W-1:0] = 20'h00001;
        push_refresh(v1);
        push_refresh(v3);
        t = done_cnt + 2;
        strobe(v1);
        wait_cond_state("midstb", 4'd10, 500);
        strobe(v2);
        repeat (20) @(negedge CLK);
        strobe(v3);
        wait_done("midstb", t, 3000);
        repeat (400) @(negedge CLK);
        compare_stream("midstb");
        check_eq("midstb_done_cnt", 64'(done_cnt), 64'(t));

        // Reset while E is high, then a strobe queued during power-on.
        strobe(rand_val());
        wait_e_high("rstmid", 500);
        #2 RST = 1'b1;
        #1;
        check_eq("rstmid_ctrl",  64'(CTRL),  64'(0));
        check_eq("rstmid_state", 64'(STATE), 64'(0));
        check_eq("rstmid_busy",  64'(BUSY),  64'(1));
        repeat (3) @(negedge CLK);
        obs_q.delete();
        exp_q.delete();
        t = done_cnt + 1;
        RST = 1'b0;
        push_init();
        v1 = rand_val();
        push_refresh(v1);
        repeat (5) @(negedge CLK);
        check_eq("pwron_state", 64'(STATE), 64'(0));
        strobe(v1);
        wait_done("rerun", t, 3000);
        compare_stream("rerun");
        check_eq("rerun_done_cnt", 64'(done_cnt), 64'(t));

        check_eq("rw_always_low", 64'(rw_bad), 64'(0));
        check_eq("done_one_cycle", 64'(done_long), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_field_drive.md
Name: lcd_field_drive

Overview:
- Parametrised successor to the fixed three-value character-LCD driver (SpO2 / heart-rate / power).
- Drives an HD44780-compatible LCD in 8-bit write-only mode: runs the power-on init sequence, then renders NCH channels of DIGITS hex digits each as ASCII.
- Sits between the measurement pipeline (packed values + strobe) and the LCD pins. Adds snapshot buffering, a pending-refresh queue, configurable timing and a busy/done handshake.

Parameters:
- NCH, 3, number of displayed channels (1..8).
- DIGITS, 5, hex digits per channel (1..7); channel width is 4*DIGITS bits.
- T_PWRON, 2000000, cycles to wait after reset before the first command (20 ms at 100 MHz).
- T_EN, 50, cycles E is held high per transfer.
- T_CMD, 5000, cycles to wait after E falls for normal commands/data.
- T_CLR, 200000, cycles to wait after E falls for the clear command.

Ports:
- CLK, in, 1, system clock.
- RST, in, 1, asynchronous active-high reset.
- VAL, in, NCH*4*DIGITS, packed channel values; channel i is VAL[i*4*DIGITS +: 4*DIGITS].
- VAL_STB, in, 1, one-cycle strobe: capture VAL and request a refresh.
- STATE, out, 4, current main state code.
- CTRL, out, 11, LCD pins {RS, RW, E, DB[7:0]}.
- BUSY, out, 1, high whenever STATE != IDLE.
- DONE, out, 1, one-cycle pulse when a refresh completes.

Behaviour:
- Reset (async): all registers clear; CTRL=0, BUSY=1, DONE=0, STATE=PWRON (0), shadow/display latches=0, pending=0.
- State codes: PWRON=0, FUNC=1 (cmd 0x38), DISP=2 (0x0C), CLR=3 (0x01), ENTRY=4 (0x06), IDLE=8, ADDR=9, DATA=10, NEXT=11.
- PWRON waits T_PWRON cycles, then steps FUNC->DISP->CLR->ENTRY->IDLE, one transfer per state.
- Each transfer has three phases:
  - setup: 1 cycle, E=0, RS/DB valid.
  - strobe: T_EN cycles, E=1.
  - hold: T_CMD cycles (T_CLR after CLR), E=0.
  - RS/DB stay stable across all three phases. RW is always 0.
- Commands use RS=0; character data uses RS=1.
- VAL_STB in any state copies VAL into the shadow register and sets pending. The latest strobe wins, and multiple strobes during a refresh collapse into one pending refresh.
- IDLE with pending=1: copy shadow into the display latch, clear pending, set ch=0, go to ADDR. A strobe in that same cycle re-sets pending.
- Refreshes render only from the display latch, so a mid-refresh strobe never tears the screen.
- ADDR writes command 0x80 | addr(ch):
  - addr = (ch%2)*0x40 + (ch/2)*(DIGITS+1).
  - Even channels go on line 1, odd channels on line 2, with one blank column between fields.
- DATA writes DIGITS characters, most significant nibble first.
  - Nibble n maps to ASCII: n<10 -> 0x30+n; otherwise 0x37+n (A-F -> 0x41-0x46).
- NEXT: if ch==NCH-1, pulse DONE for 1 cycle and go to IDLE; else ch++ and go to ADDR.
- A refresh therefore takes NCH*(1+DIGITS) transfers.
- A strobe arriving during PWRON or init is queued. The first refresh runs immediately after reaching IDLE.
- Reset mid-transfer aborts immediately: E drops the same instant, and the full power-on sequence re-runs.
- Timing counters are sized to the largest of T_PWRON/T_CMD/T_CLR; all parameters must be >= 1.

Optional Feature:
- Macro LCD_LEADING_ZERO_BLANK_EN.
- Defined: within each channel, leading zero digits are written as space (0x20). The least significant digit is always a numeral, so a value of 0 shows "    0".
- Undefined: all digits are written as hex numerals, including leading zeros.
- Transfer count and timing are identical in both builds.

Test Plan:
- Init sequence (T_PWRON=100, T_EN=4, T_CMD=10, T_CLR=40):
  - Stimulus: release RST.
  - Response: E pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0; the gap after 0x01 is >= 40 cycles; STATE reaches 8; BUSY falls.
- Basic refresh (NCH=3, DIGITS=5):
  - Stimulus: VAL={20'h54321, 20'h00055, 20'h00097}, one VAL_STB.
  - Response: commands 0x80, 0xC0, 0x86; data "00097", "00055", "54321" (e.g. 0x30 0x30 0x30 0x39 0x37); 18 E pulses; one DONE pulse.
- Hex mapping:
  - Stimulus: channel 0 = 20'hABCDE.
  - Response: data bytes 0x41, 0x42, 0x43, 0x44, 0x45.
- Strobe during refresh:
  - Stimulus: a second strobe with channel 0 = 20'h00001 while the first refresh is in DATA.
  - Response: the first refresh completes with old values unchanged; exactly one further refresh shows "00001"; two DONE pulses total.
- Reset mid-transfer:
  - Stimulus: assert RST while E=1.
  - Response: CTRL=0 and STATE=0 without waiting for a clock edge; after release, the full init sequence re-runs.
- LCD_LEADING_ZERO_BLANK_EN defined:
  - Stimulus: channel 0 = 20'h00097, channel 1 = 0.
  - Response: data "   97" (0x20 0x20 0x20 0x39 0x37) and "    0".
